// File: rtl/spider_pkg.sv
// Shared constants and helpers for the spider_hub fan-in/fan-out fixture.
package spider_pkg;

  localparam int SPIDER_CNT_W    = 16;
  localparam int SPIDER_MAX_LEGS = 16;

  typedef enum logic [0:0] {
    BODY_EMPTY = 1'b0,
    BODY_FULL  = 1'b1
  } body_state_e;

  // Index width for n legs; never narrower than one bit.
  function automatic int leg_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spider_hub_if.sv
// Leg handshake bundle of spider_hub: master drives the legs, slave is the hub.
interface spider_hub_if #(
  parameter int N_LEGS = 4,
  parameter int DATA_W = 8
);

  logic [N_LEGS-1:0]        leg_left_valid;
  logic [N_LEGS-1:0]        leg_left_ready;
  logic [N_LEGS*DATA_W-1:0] leg_left_data;
  logic [N_LEGS-1:0]        leg_right_valid;
  logic [N_LEGS-1:0]        leg_right_ready;
  logic [N_LEGS*DATA_W-1:0] leg_right_data;

  modport master (
    output leg_left_valid, leg_left_data, leg_right_ready,
    input  leg_left_ready, leg_right_valid, leg_right_data
  );

  modport slave (
    input  leg_left_valid, leg_left_data, leg_right_ready,
    output leg_left_ready, leg_right_valid, leg_right_data
  );

endinterface

// File: rtl/spider_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant searched from ptr, registered pointer.
module spider_rr_arb
  import spider_pkg::*;
#(
  parameter int N_LEGS = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_LEGS-1:0] req,
  input  logic              accept,
  output logic [N_LEGS-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_any
);

  logic [IDX_W-1:0]  ptr_r;
  logic [N_LEGS-1:0] grant_s;
  logic [IDX_W-1:0]  idx_s;
  logic              any_s;

  // First requester at ptr, ptr+1, ... with explicit wrap so indices >= N_LEGS never appear.
  always_comb begin
    int               cand_v;
    logic [IDX_W-1:0] cand_idx_v;
    logic             hit_v;
    grant_s    = {N_LEGS{1'b0}};
    idx_s      = {IDX_W{1'b0}};
    any_s      = 1'b0;
    cand_v     = 0;
    cand_idx_v = {IDX_W{1'b0}};
    hit_v      = 1'b0;
    for (int k = 0; k < N_LEGS; k++) begin
      cand_v = (int'(ptr_r) + k >= N_LEGS) ? int'(ptr_r) + k - N_LEGS : int'(ptr_r) + k;
      cand_idx_v = IDX_W'(cand_v);
      hit_v = !any_s && req[cand_idx_v];
      grant_s[cand_idx_v] = grant_s[cand_idx_v] | hit_v;
      idx_s = hit_v ? cand_idx_v : idx_s;
      any_s = any_s | hit_v;
    end
  end

  // Pointer moves just past the accepted leg, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= {IDX_W{1'b0}};
    end else if (accept && any_s) begin
      ptr_r <= (idx_s == IDX_W'(N_LEGS - 1)) ? {IDX_W{1'b0}} : idx_s + IDX_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign grant     = grant_s;
  assign grant_idx = idx_s;
  assign grant_any = any_s;

endmodule

// File: rtl/spider_hub.sv
// N-leg fan-in/fan-out through a single body register; SPIDER_HUB_STATS_EN adds
// saturating per-leg delivered-word counters on leg_count.
module spider_hub
  import spider_pkg::*;
#(
  parameter int N_LEGS = 4,
  parameter int DATA_W = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
`ifdef SPIDER_HUB_STATS_EN
  output logic [N_LEGS*SPIDER_CNT_W-1:0] leg_count,
`endif
  spider_hub_if.slave                    bus
);

  localparam int IDX_W = leg_idx_w(N_LEGS);

  logic [N_LEGS-1:0] grant_s;
  logic [IDX_W-1:0]  grant_idx_s;
  logic              grant_any_s;
  logic              right_xfer_s;
  logic              can_accept_s;
  logic              left_xfer_s;
  logic [DATA_W-1:0] sel_data_s;

  body_state_e       state_r, state_nxt_s;
  logic [N_LEGS-1:0] valid_r, valid_nxt_s;
  logic [DATA_W-1:0] data_r, data_nxt_s;

  spider_rr_arb #(
    .N_LEGS (N_LEGS),
    .IDX_W  (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.leg_left_valid),
    .accept    (left_xfer_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  // valid_r is the body index kept one-hot, so a drain is a simple AND with sink ready.
  assign right_xfer_s = |(valid_r & bus.leg_right_ready);
  assign can_accept_s = (state_r == BODY_EMPTY) || right_xfer_s;
  assign left_xfer_s  = rst_n && grant_any_s && can_accept_s;

  assign bus.leg_left_ready  = left_xfer_s ? grant_s : {N_LEGS{1'b0}};
  assign bus.leg_right_valid = valid_r;
  assign bus.leg_right_data  = {N_LEGS{data_r}};

  // One-hot mux of the granted leg's payload.
  always_comb begin
    sel_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < N_LEGS; i++) begin
      sel_data_s = sel_data_s | (bus.leg_left_data[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
    end
  end

  // Body next state: a fill always wins, so drain+fill keeps the body full with no bubble.
  always_comb begin
    state_nxt_s = state_r;
    valid_nxt_s = valid_r;
    data_nxt_s  = data_r;
    case (state_r)
      BODY_EMPTY: begin
        if (left_xfer_s) begin
          state_nxt_s = BODY_FULL;
          valid_nxt_s = grant_s;
          data_nxt_s  = sel_data_s;
        end else begin
          state_nxt_s = BODY_EMPTY;
        end
      end
      BODY_FULL: begin
        if (left_xfer_s) begin
          state_nxt_s = BODY_FULL;
          valid_nxt_s = grant_s;
          data_nxt_s  = sel_data_s;
        end else if (right_xfer_s) begin
          state_nxt_s = BODY_EMPTY;
          valid_nxt_s = {N_LEGS{1'b0}};
        end else begin
          state_nxt_s = BODY_FULL;
        end
      end
      default: begin
        state_nxt_s = BODY_EMPTY;
        valid_nxt_s = {N_LEGS{1'b0}};
      end
    endcase
  end

  // Body register; reset discards any word in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= BODY_EMPTY;
      valid_r <= {N_LEGS{1'b0}};
      data_r  <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      valid_r <= valid_nxt_s;
      data_r  <= data_nxt_s;
    end
  end

`ifdef SPIDER_HUB_STATS_EN
  logic [SPIDER_CNT_W-1:0] cnt_r [N_LEGS];

  // Per-leg delivered-word counters, saturating at all ones.
  always_ff @(posedge clk) begin
    for (int j = 0; j < N_LEGS; j++) begin
      if (!rst_n) begin
        cnt_r[j] <= {SPIDER_CNT_W{1'b0}};
      end else if (valid_r[j] && bus.leg_right_ready[j] && (cnt_r[j] != {SPIDER_CNT_W{1'b1}})) begin
        cnt_r[j] <= cnt_r[j] + SPIDER_CNT_W'(1);
      end else begin
        cnt_r[j] <= cnt_r[j];
      end
    end
  end

  for (genvar j = 0; j < N_LEGS; j++) begin : g_cnt
    assign leg_count[j*SPIDER_CNT_W +: SPIDER_CNT_W] = cnt_r[j];
  end
`endif

endmodule
